// File: rtl/argmax_scheduler.sv
// Streaming arg-max over one row of N unsigned 4-bit elements: max value, first index, tie count.
// Latency: in_ready 1 cycle after start; out_valid on the edge that captures the last element.
// Backpressure: in_valid gaps stall the scan; the result holds in OUT until out_ready.
module argmax_scheduler #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_ties
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] OUTS = 2'd2;

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   ONE_TIE  = (IDX_W + 1)'(1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [3:0]       max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   ties_q, ties_d;
  logic             out_valid_q, out_valid_d;

  logic accept;
  logic data_gt;
  logic data_eq;

  // The single shared comparator pair always sees the registered running max.
  assign data_gt = in_data > max_q;
  assign data_eq = in_data == max_q;
  assign accept  = (state_q == SCAN) && in_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    idx_d       = idx_q;
    ties_d      = ties_q;
    out_valid_d = out_valid_q;
    if (abort) begin
      state_d     = IDLE;
      cnt_d       = '0;
      max_d       = '0;
      idx_d       = '0;
      ties_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SCAN;
            cnt_d   = '0;
          end
        end
        SCAN: begin
          if (accept) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0 || data_gt) begin
              max_d  = in_data;
              idx_d  = cnt_q;
              ties_d = ONE_TIE;
            end else if (data_eq) begin
              ties_d = ties_q + 1'b1;
            end
            if (cnt_q == LAST_CNT) begin
              state_d     = OUTS;
              out_valid_d = 1'b1;
            end
          end
        end
        OUTS: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      ties_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      ties_q      <= ties_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == SCAN);
  assign busy      = (state_q == SCAN) || (state_q == OUTS);
  assign out_valid = out_valid_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_ties  = ties_q;

endmodule

// File: doc/argmax_scheduler.md
# argmax_scheduler

Sequential arg-max engine for one row of 4-bit matrix results. It accepts N elements over a valid/ready stream and uses a single shared 4-bit greater-than comparator and a single shared 4-bit equality comparator, one element per cycle. It returns the maximum value, the index of its first occurrence and the number of elements equal to it. It sits after the multiply-accumulate array and feeds max-selection and pooling logic downstream.

## Interface
- N, default 4: elements per row; legal range 2..16.
- IDX_W, default $clog2(N): index width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a new row; sampled only in IDLE.
- abort  input  1  synchronous cancel of the current row; any state goes to IDLE.
- in_valid  input  1  in_data is valid.
- in_data  input  4  unsigned element.
- in_ready  output  1  block accepts an element this cycle.
- busy  output  1  high in SCAN and OUT.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_max  output  4  maximum value of the row.
- out_idx  output  IDX_W  index of the first element equal to out_max.
- out_ties  output  IDX_W+1  count of elements equal to out_max (1..N).

## Operation
- Clock and reset are fixed: one clock, clk; asynchronous active-low reset, rst_n.
- States: IDLE, SCAN, OUT. State and all result registers reset to 0/IDLE.
- Reset values: in_ready=0, busy=0, out_valid=0, out_max=0, out_idx=0, out_ties=0.
- IDLE
  - start=1 goes to SCAN and clears the element counter cnt.
  - The result registers keep the last result.
- SCAN
  - in_ready=1. An element is accepted when in_valid && in_ready.
  - The first element (cnt==0) is loaded unconditionally: max=data, idx=0, ties=1.
  - A later element with data>max (unsigned compare) loads max=data, idx=cnt, ties=1.
  - A later element with data==max increments ties. max and idx are kept, so the first occurrence wins.
  - A later element with data<max causes no change.
  - cnt increments on every accept.
  - Accepting the element at cnt==N-1 goes to OUT.
  - Cycles with in_valid=0 are stalls. State and counters hold.
- OUT
  - out_valid=1 and the outputs hold stable until out_ready=1.
  - On out_ready=1, the state goes to IDLE and out_valid drops the next cycle.
  - start in the same cycle as the out_ready handshake is ignored; start must be reasserted in IDLE.
- abort
  - Has priority over every other input.
  - Next state is IDLE, out_valid=0 and cnt=0. Partial results are discarded (result registers are cleared to 0).
- start outside IDLE is ignored.
- Reset asserted mid-row: immediate return to IDLE with all outputs at their reset values; there is no recovery of the partial row.
- Widths: out_ties saturates naturally because at most N ≤ 2^IDX_W elements are accepted; IDX_W+1 bits hold N. All compares are 4-bit unsigned.

## Timing
- in_ready and busy decode from the registered state only; there is no combinational path from inputs to outputs.
- Result registers and out_valid are registered.
- Start to first possible accept: 1 cycle. start is sampled at edge k, and in_ready=1 from cycle k+1.
- Accept throughput: 1 element per cycle with no bubbles.
- Last accept to out_valid: 1 cycle. out_valid rises on the edge that captures element N-1.
- Minimum row time: N+2 cycles, from start through the out_ready handshake back to IDLE.
- Comparator path: in_data through the greater-than compare to the max register within one cycle. The compare always uses the registered max.
- abort applies at the next edge. If abort and an accept occur in the same cycle, the element is dropped.

## Test plan
- N=4, start, then 3,9,9,2 back-to-back, out_ready=1 → out_valid 1 cycle after 4th accept; out_max=9, out_idx=1, out_ties=2; busy low 1 cycle after handshake.
- All equal 5,5,5,5 → out_max=5, out_idx=0, out_ties=4. Then 0,1,2,15 → out_max=15, out_idx=3, out_ties=1. Then 15,0,0,0 → out_idx=0.
- Random in_valid gaps and out_ready held low 10 cycles on row 7,4,7,1 → no extra accepts, out_valid and outputs stable through the stall; out_max=7, out_idx=0, out_ties=2; exactly 4 accepts counted.
- abort after 2 accepts → IDLE next cycle; out_valid=0; result registers and counters 0; no output appears. Then start with row 2,8,8,8 → out_max=8, out_idx=1, out_ties=3. Also: start pulses during SCAN and OUT → no effect.
- rst_n low asynchronously mid-SCAN, between clock edges → all outputs 0 immediately. After release, a full row 1,2,3,4 → out_max=4, out_idx=3, out_ties=1.
- Parameter N=16 with 0..15 then reversed 15..0 → out_idx=15 and out_idx=0 respectively; out_ties=1; a 16-element all-zero row gives out_ties=16.
